// File: rtl/cnn_fmap_responder_pkg.sv
// Shared configuration for the lacc feature-map read responder.
// Tile limits, outstanding-command depth and the response word width.
package cnn_fmap_responder_pkg;

  localparam int unsigned BUFFER_WIDTH         = 8;
  localparam int unsigned BUFFER_DEPTH         = 8;
  localparam int unsigned LACC_MAX_OUTSTANDING = 4;
  localparam int unsigned LACC_DATA_W          = 32;
  localparam int unsigned WORD_BYTES           = LACC_DATA_W / 8;

  // Number of words in a tile given inclusive last-column/last-row indices.
  function automatic int unsigned tile_words(input int unsigned last_col,
                                             input int unsigned last_row);
    return (last_col + 1) * (last_row + 1);
  endfunction

endpackage

// File: rtl/cnn_addr_walker.sv
// Row-major address generator for a 2D tile, built from incremental adders.
// Holds the column/row position and the current row and column byte addresses.
module cnn_addr_walker #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned COL_W  = 3,
  parameter int unsigned ROW_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [COL_W-1:0]  last_col,
  output logic [ADDR_W-1:0] addr
);
  import cnn_fmap_responder_pkg::*;

  logic [COL_W-1:0]  x_q;
  logic [ROW_W-1:0]  y_q;
  logic [ADDR_W-1:0] row_addr_q;
  logic [ADDR_W-1:0] col_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      row_addr_q <= '0;
      col_addr_q <= '0;
    end else if (init) begin
      x_q        <= '0;
      y_q        <= '0;
      row_addr_q <= base_addr;
      col_addr_q <= base_addr;
    end else if (step) begin
      if (x_q < last_col) begin
        x_q        <= x_q + COL_W'(1);
        col_addr_q <= col_addr_q + ADDR_W'(WORD_BYTES);
      end else begin
        // Wrap to the next row; the column address restarts at the new row start.
        x_q        <= '0;
        y_q        <= y_q + ROW_W'(1);
        row_addr_q <= row_addr_q + row_stride;
        col_addr_q <= row_addr_q + row_stride;
      end
    end
  end

  assign addr = col_addr_q;

endmodule

// File: rtl/cnn_fmap_responder.sv
// Memory-side responder for the lacc feature-map read channel: accepts implicit-address
// read commands, walks a tile in row-major order and returns the words in order.
module cnn_fmap_responder #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned BUFFER_WIDTH    = cnn_fmap_responder_pkg::BUFFER_WIDTH,
  parameter int unsigned BUFFER_DEPTH    = cnn_fmap_responder_pkg::BUFFER_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = cnn_fmap_responder_pkg::LACC_MAX_OUTSTANDING
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 base_addr_i,
  input  logic [ADDR_W-1:0]                 row_stride_i,
  input  logic [$clog2(BUFFER_WIDTH)-1:0]   buffer_width_i,
  input  logic [$clog2(BUFFER_DEPTH)-1:0]   buffer_depth_i,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  input  logic                              lacc_data_valid,
  output logic                              lacc_data_ready,
  output logic                              lacc_drsp_valid,
  output logic [31:0]                       lacc_drsp_rdata,
  output logic                              mem_req,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic                              mem_gnt,
  input  logic                              mem_rvalid,
  input  logic [31:0]                       mem_rdata
);
  import cnn_fmap_responder_pkg::*;

  localparam int unsigned WW = $clog2(BUFFER_WIDTH);
  localparam int unsigned DW = $clog2(BUFFER_DEPTH);
  localparam int unsigned TW = $clog2(BUFFER_WIDTH * BUFFER_DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [TW-1:0]          total_q, accepted_q, issued_q;
  logic [OW-1:0]          pending_q, inflight_q;
  logic [OW:0]            outstanding;
  logic [ADDR_W-1:0]      stride_q;
  logic [WW-1:0]          last_col_q;
  logic                   drsp_valid_q, err_q;
  logic [LACC_DATA_W-1:0] drsp_rdata_q;
  logic                   start_fire, hs, gnt_fire, rsp_fire, drain_done;

  assign start_fire  = start && (state_q == StIdle);
  assign mem_req     = (pending_q != '0);
  assign gnt_fire    = mem_req && mem_gnt;
  assign rsp_fire    = mem_rvalid && (inflight_q != '0);
  assign outstanding = {1'b0, pending_q} + {1'b0, inflight_q};

  assign lacc_data_ready = (state_q == StRun) && (accepted_q < total_q) &&
                           (outstanding < (OW + 1)'(MAX_OUTSTANDING));
  assign hs = lacc_data_valid && lacc_data_ready;

  assign drain_done = (state_q == StDrain) && (issued_q == total_q) &&
                      (inflight_q == '0) && !drsp_valid_q;
  assign done = drain_done;
  assign busy = (state_q != StIdle) && !drain_done;
  assign err  = err_q;

  assign lacc_drsp_valid = drsp_valid_q;
  assign lacc_drsp_rdata = drsp_rdata_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accepted_q == total_q) state_d = StDrain;
      StDrain: if (drain_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      total_q    <= '0;
      accepted_q <= '0;
      issued_q   <= '0;
      stride_q   <= '0;
      last_col_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_fire) begin
        total_q    <= TW'(tile_words(32'(buffer_width_i), 32'(buffer_depth_i)));
        accepted_q <= '0;
        issued_q   <= '0;
        stride_q   <= row_stride_i;
        last_col_q <= buffer_width_i;
        err_q      <= 1'b0;
      end else begin
        if (hs)       accepted_q <= accepted_q + TW'(1);
        if (gnt_fire) issued_q   <= issued_q + TW'(1);
        if (mem_rvalid && (inflight_q == '0)) err_q <= 1'b1;
      end
    end
  end

  // Simultaneous increment and decrement leave a counter unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      unique case ({hs, gnt_fire})
        2'b10:   pending_q <= pending_q + OW'(1);
        2'b01:   pending_q <= pending_q - OW'(1);
        default: pending_q <= pending_q;
      endcase
      unique case ({gnt_fire, rsp_fire})
        2'b10:   inflight_q <= inflight_q + OW'(1);
        2'b01:   inflight_q <= inflight_q - OW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drsp_valid_q <= 1'b0;
      drsp_rdata_q <= '0;
    end else begin
      drsp_valid_q <= rsp_fire;
      if (rsp_fire) drsp_rdata_q <= mem_rdata;
    end
  end

  cnn_addr_walker #(
    .ADDR_W (ADDR_W),
    .COL_W  (WW),
    .ROW_W  (DW)
  ) u_addr_walker (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (start_fire),
    .step       (gnt_fire),
    .base_addr  (base_addr_i),
    .row_stride (stride_q),
    .last_col   (last_col_q),
    .addr       (mem_addr)
  );

endmodule
